// File: rtl/knn_nat_loader.sv
// Native-bus initiator: streams dataset words into the KNN block, starts it, polls status, reads results.
// Optional poll timeout is enabled by defining KNN_LOADER_TIMEOUT_EN.
module knn_nat_loader #(
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned PT_ADDR     = 0,
  parameter int unsigned EN_ADDR     = 1,
  parameter int unsigned STATUS_ADDR = 2,
  parameter int unsigned RES_ADDR    = 3
`ifdef KNN_LOADER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 1024
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [CNT_W-1:0]    cmd_npts,
  input  logic [CNT_W-1:0]    cmd_nres,
  input  logic                pt_valid,
  output logic                pt_ready,
  input  logic [DATA_W-1:0]   pt_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_address,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [DATA_W-1:0]   res_data,
  output logic                done,
  output logic                error
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StWrPt, StWrEn, StPoll, StRdRes, StDone} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    npts_q, npts_d;
  logic [CNT_W-1:0]    nres_q, nres_d;
  logic [CNT_W-1:0]    rk_q, rk_d;
  logic                m_valid_q, m_valid_d;
  logic [ADDR_W-1:0]   m_address_q, m_address_d;
  logic [DATA_W-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_W-1:0]   m_wstrb_q, m_wstrb_d;
  logic                res_valid_q, res_valid_d;
  logic [DATA_W-1:0]   res_data_q, res_data_d;
  logic                bus_done, bus_idle;

`ifdef KNN_LOADER_TIMEOUT_EN
  localparam int unsigned PCNT_W = $clog2(TIMEOUT + 1);
  logic [PCNT_W-1:0] poll_cnt_q, poll_cnt_d;
  logic              error_q, error_d;
  logic              timed_out;

  assign timed_out = (poll_cnt_q == PCNT_W'(TIMEOUT));
  assign error     = error_q;

  // Counter saturates at TIMEOUT so the expiry condition holds until the bus is idle.
  always_comb begin
    poll_cnt_d = '0;
    if (state_q == StPoll) begin
      poll_cnt_d = timed_out ? poll_cnt_q : poll_cnt_q + PCNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      poll_cnt_q <= '0;
      error_q    <= 1'b0;
    end else begin
      poll_cnt_q <= poll_cnt_d;
      error_q    <= error_d;
    end
  end
`else
  assign error = 1'b0;
`endif

  // Only one request in flight; a completion always leaves at least one idle cycle.
  assign bus_done = m_valid_q & m_ready;
  assign bus_idle = ~m_valid_q;

  always_comb begin
    state_d     = state_q;
    npts_d      = npts_q;
    nres_d      = nres_q;
    rk_d        = rk_q;
    m_valid_d   = m_valid_q;
    m_address_d = m_address_q;
    m_wdata_d   = m_wdata_q;
    m_wstrb_d   = m_wstrb_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    pt_ready    = 1'b0;
`ifdef KNN_LOADER_TIMEOUT_EN
    error_d     = error_q;
`endif

    if (res_valid_q && res_ready) res_valid_d = 1'b0;
    if (bus_done) m_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          npts_d  = cmd_npts;
          nres_d  = cmd_nres;
          rk_d    = '0;
          state_d = StWrPt;
`ifdef KNN_LOADER_TIMEOUT_EN
          error_d = 1'b0;
`endif
        end
      end
      StWrPt: begin
        if (bus_done) begin
          npts_d = npts_q - CNT_W'(1);
        end else if (bus_idle) begin
          if (npts_q == '0) begin
            state_d = StWrEn;
          end else if (pt_valid) begin
            pt_ready    = 1'b1;
            m_valid_d   = 1'b1;
            m_address_d = ADDR_W'(PT_ADDR);
            m_wdata_d   = pt_data;
            m_wstrb_d   = '1;
          end
        end
      end
      StWrEn: begin
        if (bus_done) begin
          state_d = StPoll;
        end else if (bus_idle) begin
          m_valid_d   = 1'b1;
          m_address_d = ADDR_W'(EN_ADDR);
          m_wdata_d   = DATA_W'(1);
          m_wstrb_d   = '1;
        end
      end
      StPoll: begin
        if (bus_done) begin
          if (m_rdata[0]) state_d = StRdRes;
`ifdef KNN_LOADER_TIMEOUT_EN
        end else if (bus_idle && timed_out) begin
          error_d = 1'b1;
          state_d = StDone;
`endif
        end else if (bus_idle) begin
          m_valid_d   = 1'b1;
          m_address_d = ADDR_W'(STATUS_ADDR);
          m_wdata_d   = '0;
          m_wstrb_d   = '0;
        end
      end
      StRdRes: begin
        if (bus_done) begin
          res_valid_d = 1'b1;
          res_data_d  = m_rdata;
          nres_d      = nres_q - CNT_W'(1);
          rk_d        = rk_q + CNT_W'(1);
        end else if (bus_idle) begin
          if (nres_q == '0) begin
            state_d = StDone;
          end else if (!res_valid_q) begin
            // Result address wraps within the native address space.
            m_valid_d   = 1'b1;
            m_address_d = ADDR_W'(RES_ADDR) + ADDR_W'(rk_q);
            m_wdata_d   = '0;
            m_wstrb_d   = '0;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      npts_q      <= '0;
      nres_q      <= '0;
      rk_q        <= '0;
      m_valid_q   <= 1'b0;
      m_address_q <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      npts_q      <= npts_d;
      nres_q      <= nres_d;
      rk_q        <= rk_d;
      m_valid_q   <= m_valid_d;
      m_address_q <= m_address_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign cmd_ready = (state_q == StIdle) & rst;
  assign done      = (state_q == StDone);
  assign m_valid   = m_valid_q;
  assign m_address = m_address_q;
  assign m_wdata   = m_wdata_q;
  assign m_wstrb   = m_wstrb_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_knn_nat_loader.sv
// Scoreboard bench for knn_nat_loader: behavioural KNN slave, expected bus/result queues, directed commands.
module tb_knn_nat_loader;
  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_npts = '0;
  logic [CW-1:0] cmd_nres = '0;
  logic          pt_valid = 1'b0;
  logic          pt_ready;
  logic [DW-1:0] pt_data = '0;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [DW-1:0] m_wdata;
  logic [3:0]    m_wstrb;
  logic [DW-1:0] m_rdata = '0;
  logic          m_ready = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b1;
  logic [DW-1:0] res_data;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  knn_nat_loader #(
`ifdef KNN_LOADER_TIMEOUT_EN
    .TIMEOUT(16)
`endif
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_npts(cmd_npts), .cmd_nres(cmd_nres), .pt_valid(pt_valid), .pt_ready(pt_ready),
    .pt_data(pt_data), .m_valid(m_valid), .m_address(m_address), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .done(done), .error(error)
  );

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} bus_t;

  bus_t          exp_bus[$];
  logic [DW-1:0] exp_res[$];
  logic [DW-1:0] pts[$];
  bus_t          e;
  logic [DW-1:0] er;
  int total = 0, bad = 0;
  int log_cnt = 0, done_cnt = 0, ptr_cnt = 0;
  int status_cnt = 0, status_after = 1, seen = 0;
  bit loose_status = 1'b0, prev_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Slave: completes each request one cycle after it is first seen.
  initial forever begin
    @(negedge clk);
    if (!rst || m_ready) begin
      m_ready = 1'b0;
      seen    = 0;
    end else if (m_valid) begin
      if (seen == 0) begin
        seen = 1;
      end else begin
        if (m_wstrb == 4'h0 && m_address == 5'd2) begin
          status_cnt++;
          m_rdata = (status_cnt >= status_after) ? 32'h1 : 32'h0;
        end else begin
          m_rdata = 32'hA500_0000 | 32'(m_address);
        end
        m_ready = 1'b1;
      end
    end
  end

  // Monitor: bus completions, result handshakes, pulse counters.
  initial forever begin
    @(negedge clk);
    #1;
    if (prev_rdy) check("valid_drop_after_ready", m_valid, 0);
    prev_rdy = m_valid && m_ready;
    if (m_valid && m_ready) begin
      log_cnt++;
      if (!(loose_status && m_wstrb == 4'h0 && m_address == 5'd2)) begin
        if (exp_bus.size() == 0) begin
          total++;
          bad++;
          $display("FAIL bus_unexpected: got addr %0d strb %0h, none required", m_address, m_wstrb);
        end else begin
          e = exp_bus.pop_front();
          check("bus_is_write", m_wstrb != 4'h0, e.we);
          check("bus_addr", m_address, e.addr);
          if (e.we) begin
            check("bus_wdata", m_wdata, e.data);
            check("bus_wstrb", m_wstrb, 4'hF);
          end
        end
      end
    end
    if (res_valid && m_valid) check("read_while_slot_full", m_wstrb == 4'h0, 0);
    if (res_valid && res_ready) begin
      if (exp_res.size() == 0) begin
        total++;
        bad++;
        $display("FAIL res_unexpected: got %0h, none required", res_data);
      end else begin
        er = exp_res.pop_front();
        check("res_data", res_data, er);
      end
    end
    if (done) done_cnt++;
    if (pt_ready) ptr_cnt++;
  end

  task automatic push_w(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_bus.push_back(bus_t'{we: 1'b1, addr: a, data: d});
  endtask

  task automatic push_r(input logic [AW-1:0] a);
    exp_bus.push_back(bus_t'{we: 1'b0, addr: a, data: '0});
  endtask

  task automatic issue_cmd(input int n, input int r);
    @(posedge clk);
    #1;
    cmd_npts  = CW'(n);
    cmd_nres  = CW'(r);
    cmd_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (cmd_ready) break;
    end
    check("cmd_accept", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic feed(input int gap);
    for (int i = 0; i < pts.size(); i++) begin
      @(posedge clk);
      #1;
      pt_valid = 1'b1;
      pt_data  = pts[i];
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        #1;
        if (pt_ready) break;
      end
      @(posedge clk);
      #1;
      pt_valid = 1'b0;
      repeat (gap) @(posedge clk);
    end
  endtask

  task automatic wait_done(input int d0);
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (done_cnt != d0) break;
    end
    repeat (3) @(posedge clk);
    check("done_pulses", done_cnt - d0, 1);
  endtask

  task automatic run_cmd(input int n, input int r, input int gap);
    int d0;
    d0 = done_cnt;
    issue_cmd(n, r);
    fork
      feed(gap);
      wait_done(d0);
    join
  endtask

  task automatic queues_empty();
    check("bus_queue_empty", exp_bus.size(), 0);
    check("res_queue_empty", exp_res.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, l0;
    #3;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_error", error, 0);

    // Basic: three points, two results, status ready on first poll.
    pts = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    push_w(0, 32'h1111_1111); push_w(0, 32'h2222_2222); push_w(0, 32'h3333_3333);
    push_w(1, 32'h1); push_r(2); push_r(3); push_r(4);
    exp_res.push_back(32'hA500_0003); exp_res.push_back(32'hA500_0004);
    status_cnt = 0; status_after = 1; p0 = ptr_cnt;
    run_cmd(3, 2, 0);
    check("basic_pt_ready_pulses", ptr_cnt - p0, 3);
    queues_empty();

    // Gapped point source, no results, status on second poll.
    pts = '{32'h4444_4444, 32'h5555_5555, 32'h6666_6666};
    push_w(0, 32'h4444_4444); push_w(0, 32'h5555_5555); push_w(0, 32'h6666_6666);
    push_w(1, 32'h1); push_r(2); push_r(2);
    status_cnt = 0; status_after = 2; p0 = ptr_cnt;
    run_cmd(3, 0, 3);
    check("gap_pt_ready_pulses", ptr_cnt - p0, 3);
    queues_empty();

    // Result backpressure: slot held full for 10 cycles.
    pts = {};
    push_w(1, 32'h1); push_r(2); push_r(3); push_r(4);
    exp_res.push_back(32'hA500_0003); exp_res.push_back(32'hA500_0004);
    status_cnt = 0; status_after = 1; res_ready = 1'b0;
    fork
      run_cmd(0, 2, 0);
      begin
        for (int c = 0; c < 500; c++) begin
          @(negedge clk);
          #1;
          if (res_valid) break;
        end
        l0 = log_cnt;
        repeat (10) @(posedge clk);
        check("bp_no_read_while_full", log_cnt - l0, 0);
        check("bp_slot_held", res_valid, 1);
        #1;
        res_ready = 1'b1;
      end
    join
    queues_empty();

    // Status set on fifth poll.
    pts = '{32'hDEAD_BEEF};
    push_w(0, 32'hDEAD_BEEF); push_w(1, 32'h1);
    for (int i = 0; i < 5; i++) push_r(2);
    push_r(3);
    exp_res.push_back(32'hA500_0003);
    status_cnt = 0; status_after = 5;
    run_cmd(1, 1, 0);
    check("poll_status_reads", status_cnt, 5);
    queues_empty();

    // Empty command: enable, poll, done.
    pts = {};
    push_w(1, 32'h1); push_r(2);
    status_cnt = 0; status_after = 1;
    run_cmd(0, 0, 0);
    check("empty_error", error, 0);
    queues_empty();

    // Reset while a point write is outstanding.
    push_w(0, 32'h7777_7777);
    l0 = log_cnt;
    issue_cmd(3, 0);
    pts = '{32'h7777_7777};
    feed(0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (log_cnt != l0) break;
    end
    @(posedge clk);
    #1;
    pt_valid = 1'b1;
    pt_data  = 32'h8888_8888;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      if (pt_ready) break;
    end
    @(posedge clk);
    #1;
    pt_valid = 1'b0;
    check("pre_rst_m_valid", m_valid, 1);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", m_valid, 0);
    check("mid_rst_m_address", m_address, 0);
    check("mid_rst_m_wdata", m_wdata, 0);
    check("mid_rst_m_wstrb", m_wstrb, 0);
    check("mid_rst_cmd_ready", cmd_ready, 0);
    check("mid_rst_pt_ready", pt_ready, 0);
    check("mid_rst_res_valid", res_valid, 0);
    check("mid_rst_done", done, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("rerst_cmd_ready", cmd_ready, 1);
    pts = '{32'h9999_9999};
    push_w(0, 32'h9999_9999); push_w(1, 32'h1); push_r(2); push_r(3);
    exp_res.push_back(32'hA500_0003);
    status_cnt = 0; status_after = 1;
    run_cmd(1, 1, 0);
    queues_empty();

`ifdef KNN_LOADER_TIMEOUT_EN
    // Status never set: timeout raises error, no result reads.
    pts = {};
    push_w(1, 32'h1);
    status_cnt = 0; status_after = 1000000; loose_status = 1'b1;
    run_cmd(0, 2, 0);
    check("timeout_error", error, 1);
    loose_status = 1'b0;
    queues_empty();
    push_w(1, 32'h1); push_r(2);
    status_cnt = 0; status_after = 1;
    issue_cmd(0, 0);
    check("timeout_error_cleared", error, 0);
    repeat (30) @(posedge clk);
    queues_empty();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
